// File: rtl/mdr_seq_core.sv
// Sequential signed multiply / divide / square-root engine of width DW.
// One iteration per cycle, with a start/ready/done handshake.
module mdr_seq_core #(
   parameter int DW = 16,
   parameter int CW = $clog2(DW + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [1:0]    i_op,
   input  logic [DW-1:0] i_data_x,
   input  logic [DW-1:0] i_data_y,
   output logic          o_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_error,
   output logic [DW-1:0] o_result,
   output logic [DW-1:0] o_remainder
);

   localparam int HW = DW / 2;
   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;
   localparam logic [1:0] OP_SQRT = 2'b10;
   localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [2*DW-1:0] MUL_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [DW-1:0]     x_q, x_d, y_q, y_d;
   logic [DW-1:0]     magB_q, magB_d;
   logic [2*DW-1:0]   acc_q, acc_d;
   logic [DW+1:0]     sqRem_q, sqRem_d;
   logic [HW-1:0]     sqRoot_q, sqRoot_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              resNeg_q, resNeg_d, remNeg_q, remNeg_d;
   logic              error_q, error_d;
   logic [DW-1:0]     result_q, result_d, remainder_q, remainder_d;

   logic [DW-1:0]     magX, magY;
   logic              chkErr;
   logic [DW:0]       mulSum, divShift;
   logic              divGe;
   logic [2*DW-1:0]   accMul, accDiv, accSqrt;
   logic [DW+1:0]     sqShift, sqNext;
   logic [DW-1:0]     sqRemFinal, mulRes, divQ, divR;
   logic              mulOvf;

   // Datapath helpers; the accumulator is shared by all three algorithms.
   always_comb begin
      magX = x_q[DW-1] ? (~x_q + ONE) : x_q;
      magY = y_q[DW-1] ? (~y_q + ONE) : y_q;
      chkErr = (op_q == 2'b11)
             || ((op_q == OP_DIV) && ((y_q == '0) || ((x_q == MIN_NEG) && (y_q == '1))))
             || ((op_q == OP_SQRT) && x_q[DW-1]);

      mulSum = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, magB_q} : {(DW+1){1'b0}});
      accMul = {mulSum, acc_q[DW-1:1]};

      divShift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
      divGe = divShift >= {1'b0, magB_q};
      accDiv = divGe ? {DW'(divShift - {1'b0, magB_q}), acc_q[DW-2:0], 1'b1}
                     : {divShift[DW-1:0], acc_q[DW-2:0], 1'b0};

      // Non-restoring root: remainder may go negative and is corrected once at the end.
      sqShift = (sqRem_q << 2) + {{DW{1'b0}}, acc_q[DW-1:DW-2]};
      sqNext = sqRem_q[DW+1] ? (sqShift + {{(DW-HW){1'b0}}, sqRoot_q, 2'b11})
                             : (sqShift - {{(DW-HW){1'b0}}, sqRoot_q, 2'b01});
      accSqrt = {acc_q[2*DW-1:DW], acc_q[DW-3:0], 2'b00};
      sqRemFinal = sqRem_q[DW+1] ? DW'(sqRem_q + {{(DW-HW+1){1'b0}}, sqRoot_q, 1'b1})
                                 : DW'(sqRem_q);

      mulOvf = resNeg_q ? (acc_q > MUL_LIM) : (acc_q >= MUL_LIM);
      mulRes = resNeg_q ? (~acc_q[DW-1:0] + ONE) : acc_q[DW-1:0];
      divQ = resNeg_q ? (~acc_q[DW-1:0] + ONE) : acc_q[DW-1:0];
      divR = remNeg_q ? (~acc_q[2*DW-1:DW] + ONE) : acc_q[2*DW-1:DW];
   end

   always_comb begin
      state_d = state_q;
      op_d = op_q;
      x_d = x_q;
      y_d = y_q;
      magB_d = magB_q;
      acc_d = acc_q;
      sqRem_d = sqRem_q;
      sqRoot_d = sqRoot_q;
      cnt_d = cnt_q;
      resNeg_d = resNeg_q;
      remNeg_d = remNeg_q;
      error_d = error_q;
      result_d = result_q;
      remainder_d = remainder_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               op_d = i_op;
               x_d = i_data_x;
               y_d = i_data_y;
               error_d = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (chkErr) begin
               error_d = 1'b1;
               result_d = '0;
               remainder_d = '0;
               state_d = DONE;
            end else begin
               resNeg_d = x_q[DW-1] ^ y_q[DW-1];
               remNeg_d = x_q[DW-1];
               sqRem_d = '0;
               sqRoot_d = '0;
               state_d = RUN;
               case (op_q)
                  OP_MUL: begin
                     magB_d = magX;
                     acc_d = {{DW{1'b0}}, magY};
                     cnt_d = CW'(DW);
                  end
                  OP_DIV: begin
                     magB_d = magY;
                     acc_d = {{DW{1'b0}}, magX};
                     cnt_d = CW'(DW);
                  end
                  default: begin
                     magB_d = '0;
                     acc_d = {{DW{1'b0}}, x_q};
                     cnt_d = CW'(HW);
                  end
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
            case (op_q)
               OP_MUL: acc_d = accMul;
               OP_DIV: acc_d = accDiv;
               default: begin
                  acc_d = accSqrt;
                  sqRem_d = sqNext;
                  sqRoot_d = {sqRoot_q[HW-2:0], ~sqNext[DW+1]};
               end
            endcase
         end
         FIX: begin
            state_d = DONE;
            case (op_q)
               OP_MUL: begin
                  error_d = mulOvf;
                  result_d = mulOvf ? '0 : mulRes;
                  remainder_d = '0;
               end
               OP_DIV: begin
                  result_d = divQ;
                  remainder_d = divR;
               end
               default: begin
                  result_d = {{(DW-HW){1'b0}}, sqRoot_q};
                  remainder_d = sqRemFinal;
               end
            endcase
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q <= '0;
         x_q <= '0;
         y_q <= '0;
         magB_q <= '0;
         acc_q <= '0;
         sqRem_q <= '0;
         sqRoot_q <= '0;
         cnt_q <= '0;
         resNeg_q <= 1'b0;
         remNeg_q <= 1'b0;
         error_q <= 1'b0;
         result_q <= '0;
         remainder_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         x_q <= x_d;
         y_q <= y_d;
         magB_q <= magB_d;
         acc_q <= acc_d;
         sqRem_q <= sqRem_d;
         sqRoot_q <= sqRoot_d;
         cnt_q <= cnt_d;
         resNeg_q <= resNeg_d;
         remNeg_q <= remNeg_d;
         error_q <= error_d;
         result_q <= result_d;
         remainder_q <= remainder_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_busy = ~o_ready;
   assign o_done = (state_q == DONE);
   assign o_error = error_q;
   assign o_result = result_q;
   assign o_remainder = remainder_q;

endmodule

// File: tb/tb_mdr_seq_core.sv
// Self-checking bench for mdr_seq_core: directed plan cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_mdr_seq_core;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [1:0]    i_op;
   logic [DW-1:0] i_data_x, i_data_y;
   logic          o_ready, o_busy, o_done, o_error;
   logic [DW-1:0] o_result, o_remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdr_seq_core #(.DW(DW)) dut (
      .clk(clk),
      .rst(rst),
      .i_start(i_start),
      .i_op(i_op),
      .i_data_x(i_data_x),
      .i_data_y(i_data_y),
      .o_ready(o_ready),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_error(o_error),
      .o_result(o_result),
      .o_remainder(o_remainder)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference: plain integer arithmetic, latency in edges counting the start-sampling edge as 1.
   task automatic model(input logic [1:0] op, input logic signed [DW-1:0] x,
                        input logic signed [DW-1:0] y,
                        output int res, output int rem, output int err, output int lat);
      longint sx, sy, p;
      int r;
      sx = x;
      sy = y;
      res = 0;
      rem = 0;
      err = 0;
      lat = DW + 3;
      case (op)
         2'b00: begin
            p = sx * sy;
            if (p < -32768 || p > 32767) err = 1;
            else res = int'(p);
         end
         2'b01: begin
            if (sy == 0 || (sx == -32768 && sy == -1)) begin
               err = 1;
               lat = 2;
            end else begin
               res = int'(sx / sy);
               rem = int'(sx % sy);
            end
         end
         2'b10: begin
            if (sx < 0) begin
               err = 1;
               lat = 2;
            end else begin
               r = 0;
               while (longint'(r + 1) * longint'(r + 1) <= sx) r++;
               res = r;
               rem = int'(sx - longint'(r) * longint'(r));
               lat = DW / 2 + 3;
            end
         end
         default: begin
            err = 1;
            lat = 2;
         end
      endcase
   endtask

   // Runs one operation; inputs are scrambled after capture, optional start pulse at edge "poke".
   task automatic applyStimulus(input logic [1:0] op, input logic signed [DW-1:0] x,
                                input logic signed [DW-1:0] y, input int poke);
      int expRes, expRem, expErr, expLat, n, readyBad;
      logic seenDone;
      model(op, x, y, expRes, expRem, expErr, expLat);
      @(posedge clk);
      #1;
      checkOutput("ready_idle", int'(o_ready), 1);
      i_start = 1'b1;
      i_op = op;
      i_data_x = x;
      i_data_y = y;
      n = 0;
      readyBad = 0;
      seenDone = 1'b0;
      while (n < 60 && !seenDone) begin
         @(posedge clk);
         #1;
         n++;
         i_start = 1'b0;
         i_op = 2'($urandom);
         i_data_x = 16'($urandom);
         i_data_y = 16'($urandom);
         if (n == poke) i_start = 1'b1;
         if (o_ready) readyBad++;
         if (o_done) seenDone = 1'b1;
      end
      checkOutput("latency", n, expLat);
      checkOutput("ready_low", readyBad, 0);
      checkOutput("busy_in_done", int'(o_busy), 1);
      checkOutput("error", int'(o_error), expErr);
      checkOutput("result", int'($signed(o_result)), expRes);
      checkOutput("remainder", int'($signed(o_remainder)), expRem);
   endtask

   initial begin
      int doneCount;
      logic [1:0] rop;
      logic signed [DW-1:0] rx, ry;
      rst = 1'b0;
      i_start = 1'b0;
      i_op = 2'b00;
      i_data_x = '0;
      i_data_y = '0;
      #12;
      checkOutput("rst_ready", int'(o_ready), 1);
      checkOutput("rst_busy", int'(o_busy), 0);
      checkOutput("rst_done", int'(o_done), 0);
      checkOutput("rst_error", int'(o_error), 0);
      checkOutput("rst_result", int'(o_result), 0);
      checkOutput("rst_remainder", int'(o_remainder), 0);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus(2'b00, 16'sd7, -16'sd6, 0);
      applyStimulus(2'b01, -16'sd17, 16'sd5, 0);
      applyStimulus(2'b01, 16'sd17, -16'sd5, 0);
      applyStimulus(2'b01, 16'sd100, 16'sd0, 0);
      applyStimulus(2'b01, -16'sd32768, -16'sd1, 0);
      applyStimulus(2'b11, 16'sd9, 16'sd3, 0);
      applyStimulus(2'b10, 16'sd200, 16'sd0, 0);
      applyStimulus(2'b10, 16'sd32767, 16'sd0, 0);
      applyStimulus(2'b10, -16'sd1, 16'sd0, 0);
      applyStimulus(2'b00, 16'sd300, 16'sd200, 0);
      applyStimulus(2'b00, -16'sd256, 16'sd128, 0);
      applyStimulus(2'b01, -16'sd32768, 16'sd1, 0);
      applyStimulus(2'b00, -16'sd32768, 16'sd1, 0);
      applyStimulus(2'b10, 16'sd0, 16'sd0, 0);
      applyStimulus(2'b00, 16'sd7, -16'sd6, 5);

      // Reset during RUN must abort at once with no done pulse afterwards.
      @(posedge clk);
      #1;
      i_start = 1'b1;
      i_op = 2'b01;
      i_data_x = 16'sd1000;
      i_data_y = 16'sd7;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("abort_ready", int'(o_ready), 1);
      checkOutput("abort_busy", int'(o_busy), 0);
      checkOutput("abort_done", int'(o_done), 0);
      checkOutput("abort_result", int'(o_result), 0);
      checkOutput("abort_remainder", int'(o_remainder), 0);
      @(negedge clk);
      rst = 1'b1;
      doneCount = 0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (o_done) doneCount++;
      end
      checkOutput("abort_no_done", doneCount, 0);
      checkOutput("abort_ready_after", int'(o_ready), 1);

      for (int k = 0; k < 40; k++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin
               rx = 16'($urandom);
               ry = 16'($urandom);
            end
            1: begin
               rx = 16'($urandom_range(0, 400)) - 16'sd200;
               ry = 16'($urandom_range(0, 400)) - 16'sd200;
            end
            2: begin
               rx = -16'sd32768;
               ry = 16'($urandom_range(0, 6)) - 16'sd3;
            end
            default: begin
               rx = 16'($urandom);
               ry = 16'($urandom_range(0, 16)) - 16'sd8;
            end
         endcase
         applyStimulus(rop, rx, ry, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdr_seq_core.md
Name: mdr_seq_core

Overview:
- Parametrised sequential multiply/divide/square-root engine.
- Generalises the fixed-width MDR datapath to width DW, with signed operands and single-cycle operand capture in place of the two-step X/Y load.
- Adds multiply overflow detection, square root with remainder, and a start/ready/done handshake.
- Sits between operand registers/control FSM and the result display/output stage.

Parameters:
- DW, 16: operand and result width in bits, two's complement; must be even and >= 4.
- CW, $clog2(DW+1): iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- i_start  input  1  start request; sampled only while o_ready=1.
- i_op  input  2  operation: 00 MUL, 01 DIV, 10 SQRT, 11 reserved.
- i_data_x  input  DW  signed operand X: multiplicand / dividend / radicand.
- i_data_y  input  DW  signed operand Y: multiplier / divisor; ignored for SQRT.
- o_ready  output  1  idle, accepts i_start.
- o_busy  output  1  operation in progress; equals ~o_ready.
- o_done  output  1  one-cycle pulse; results valid.
- o_error  output  1  error flag of last operation; held until next accepted start.
- o_result  output  DW  signed product / quotient / root.
- o_remainder  output  DW  signed remainder; 0 for MUL.

Behaviour:
- Reset (rst=0, async): state IDLE; o_ready=1, o_busy=0, o_done=0, o_error=0, o_result=0, o_remainder=0. Reset asserted mid-operation aborts immediately; no o_done is issued.
- FSM states: IDLE, CHECK, RUN, FIX, DONE.
- IDLE: o_ready=1. On i_start=1, capture i_op, i_data_x, i_data_y; clear o_error; go to CHECK. Outputs o_result/o_remainder keep their previous values until DONE.
- CHECK (1 cycle):
  - Error if op=11, DIV with Y=0, DIV with X=-2^(DW-1) and Y=-1, or SQRT with X<0.
  - On error: go to DONE with o_error=1, o_result=0, o_remainder=0.
  - Otherwise: store operand magnitudes and result signs, load counter with N, go to RUN.
- RUN: one iteration per cycle, counter decrements; go to FIX when counter reaches 0.
  - MUL: shift-add on |X|,|Y| into a 2*DW-bit accumulator; N=DW.
  - DIV: restoring division on |X|,|Y|; N=DW.
  - SQRT: non-restoring digit-by-digit root, 2 radicand bits per cycle; N=DW/2.
- FIX (1 cycle): apply signs, then go to DONE.
  - MUL: result sign = sign X xor sign Y. If the signed 2*DW product is outside [-2^(DW-1), 2^(DW-1)-1], set o_error=1 and zero both outputs; else o_result = low DW bits, o_remainder=0.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend; X = Q*Y + R with |R| < |Y|.
  - SQRT: o_result = floor(sqrt(X)); o_remainder = X - o_result^2, in range 0..2*o_result.
- DONE (1 cycle): o_done=1, outputs registered and stable; go to IDLE. o_ready is low in DONE.
- Latency, counted in rising edges from the edge that samples i_start to the edge entering DONE:
  - error detected in CHECK: 2;
  - MUL and DIV: DW+3;
  - SQRT: DW/2+3.
  - Accepted start to o_done therefore spans that many cycles. Back-to-back: next i_start is accepted in the cycle after DONE.
- i_start while busy: ignored, no queueing. Operand or i_op changes after capture have no effect.
- All arithmetic is internally DW+1 bits, so magnitude -2^(DW-1) is handled; |-2^(DW-1)| = 2^(DW-1) is a valid input to every operation except the flagged DIV case.

Test Plan:
- DW=16, MUL X=7, Y=-6 -> o_done at edge 19; o_result=-42, o_remainder=0, o_error=0; o_ready=0 for edges 1..19.
- DIV X=-17, Y=5 -> o_result=-3, o_remainder=-2. DIV X=17, Y=-5 -> o_result=-3, o_remainder=2. Both: o_done at edge 19, o_error=0.
- DIV X=100, Y=0 -> o_done at edge 2, o_error=1, result and remainder 0. DIV X=-32768, Y=-1 -> same error response. op=11 -> same error response.
- SQRT X=200 -> o_done at edge 11, o_result=14, o_remainder=4. SQRT X=32767 -> o_result=181, o_remainder=6. SQRT X=-1 -> error at edge 2.
- MUL X=300, Y=200 -> o_error=1, outputs 0, o_done at edge 19. MUL X=-256, Y=128 -> o_result=-32768, o_error=0.
- Pulse i_start again during RUN with new operands -> ignored; original result is returned. Assert rst low during RUN -> all outputs 0 immediately, o_ready=1 after release, and no o_done pulse appears.
